// File: rtl/audio_recorder.sv
// audio_recorder
//   Capture engine: drains mono samples from the codec ADC read path, applies
//   a saturating left-shift gain and packs two samples per 32-bit word
//   (first sample in [15:0], second in [31:16]). Each word is written to
//   sample memory through an Avalon-MM write master at consecutive word
//   addresses 0..NUM_WORDS-1. The layout matches what the playback engine reads.
//
// Ports
//   CLOCK_50         system clock, all logic on posedge
//   rst_n            synchronous active-low reset
//   start            level; starts a capture when seen high in IDLE or DONE
//   read_ready       codec has an ADC sample available
//   readdata_left    signed ADC sample (captured channel)
//   readdata_right   ADC right sample (not used)
//   read_s           codec read strobe (one-cycle pulse per consumed sample)
//   mem_write        Avalon-MM write request
//   mem_address      word address
//   mem_writedata    packed sample pair {second, first}
//   mem_byteenable   always 4'b1111
//   mem_waitrequest  Avalon-MM stall
//   busy             high while capturing (not IDLE, not DONE)
//   done             high in DONE
//   state_dbg        current FSM state, for observation only
//
// Handshakes
//   Codec: a sample is consumed when read_ready is seen high in a WAIT state;
//   read_s is then pulsed for one cycle and the FSM waits for read_ready to
//   drop before looking for the next sample, so one sample is never taken
//   twice. Memory: a write is presented with mem_write=1 and held (address
//   and data stable) until a posedge where mem_waitrequest=0; that posedge
//   completes the transfer.

module audio_recorder #(
    parameter int NUM_WORDS  = 1048576,
    parameter int GAIN_SHIFT = 6
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        start,
    input  logic        read_ready,
    input  logic [15:0] readdata_left,
    input  logic [15:0] readdata_right,
    output logic        read_s,
    output logic        mem_write,
    output logic [22:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RDY1 = 3'd1,
        ACK1      = 3'd2,
        WAIT_RDY2 = 3'd3,
        ACK2      = 3'd4,
        WRITE     = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam int                     YW        = 16 + GAIN_SHIFT;
    localparam logic signed [YW-1:0]   SAT_MAX   = YW'(32767);
    localparam logic signed [YW-1:0]   SAT_MIN   = YW'(-32768);
    localparam logic [22:0]            LAST_ADDR = 23'(NUM_WORDS - 1);

    state_t      state;
    logic [15:0] lo;
    logic [15:0] hi;

    // The right channel is deliberately not recorded.
    logic unused_right;
    assign unused_right = ^readdata_right;

    assign mem_byteenable = 4'b1111;
    assign state_dbg      = state;

    // Shift at full width so no magnitude bits are lost before the clamp.
    function automatic logic [15:0] apply_gain(input logic [15:0] x);
        logic signed [YW-1:0] y;
        y = YW'($signed(x)) <<< GAIN_SHIFT;
        if (y > SAT_MAX)
            return 16'h7FFF;
        else if (y < SAT_MIN)
            return 16'h8000;
        else
            return y[15:0];
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state         <= IDLE;
            read_s        <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lo            <= '0;
            hi            <= '0;
        end else begin
            read_s <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_address <= '0;
                        busy        <= 1'b1;
                        state       <= WAIT_RDY1;
                    end
                end
                WAIT_RDY1: begin
                    if (read_ready) begin
                        lo     <= apply_gain(readdata_left);
                        read_s <= 1'b1;
                        state  <= ACK1;
                    end
                end
                ACK1: begin
                    // Wait for the codec to retire the sample just taken.
                    if (!read_ready)
                        state <= WAIT_RDY2;
                end
                WAIT_RDY2: begin
                    if (read_ready) begin
                        hi     <= apply_gain(readdata_left);
                        read_s <= 1'b1;
                        state  <= ACK2;
                    end
                end
                ACK2: begin
                    if (!read_ready) begin
                        mem_writedata <= {hi, lo};
                        mem_write     <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (!mem_waitrequest) begin
                        mem_write <= 1'b0;
                        if (mem_address == LAST_ADDR) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            mem_address <= mem_address + 23'd1;
                            state       <= WAIT_RDY1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        mem_address <= '0;
                        state       <= WAIT_RDY1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder (NUM_WORDS=4, GAIN_SHIFT=6).
// A codec model feeds queued samples, a memory slave model applies scheduled
// waitrequest stalls, and a monitor compares every completed write against
// the expected queue filled at stimulus time.

module tb_audio_recorder;

    localparam int TB_WORDS = 4;
    localparam int TB_GAIN  = 6;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic        start;
    logic        read_ready      = 1'b0;
    logic [15:0] readdata_left   = 16'h0;
    logic [15:0] readdata_right  = 16'h0;
    logic        mem_waitrequest = 1'b0;
    logic        read_s;
    logic        mem_write;
    logic [22:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_recorder #(.NUM_WORDS(TB_WORDS), .GAIN_SHIFT(TB_GAIN)) dut (
        .CLOCK_50        (CLOCK_50),
        .rst_n           (rst_n),
        .start           (start),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read_s          (read_s),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .busy            (busy),
        .done            (done),
        .state_dbg       (state_dbg)
    );

    int tests = 0;
    int fails = 0;
    int reads = 0;
    int writes = 0;

    // Expected entry: {stall cycles[7:0], address[22:0], data[31:0]}
    logic [62:0] exp_q[$];
    int          stall_q[$];
    logic [15:0] fifo[$];
    logic [22:0] next_addr;

    // Monitor / model state
    logic        prev_rs = 1'b0;
    logic        prev_stall = 1'b0;
    logic [22:0] pa = '0;
    logic [31:0] pd = '0;
    logic [62:0] e;
    int          gap = 0;
    int          stall_left = 0;
    int          stall_run = 0;
    bit          write_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference gain: multiply by 2^GAIN and clamp to the 16-bit signed range.
    function automatic logic [15:0] model_gain(input logic [15:0] x);
        int y;
        y = int'($signed(x)) * (1 << TB_GAIN);
        if (y > 32767) return 16'h7FFF;
        if (y < -32768) return 16'h8000;
        return 16'(y);
    endfunction

    function automatic logic [15:0] rand_sample();
        if ($urandom_range(0, 1) == 1)
            return 16'($urandom_range(0, 65535));
        return 16'(int'($urandom_range(0, 1200)) - 600);
    endfunction

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b,
                             input int stall, input logic [31:0] word);
        fifo.push_back(a);
        fifo.push_back(b);
        stall_q.push_back(stall);
        exp_q.push_back({8'(stall), next_addr, word});
        next_addr = next_addr + 23'd1;
    endtask

    task automatic push_random_pair();
        logic [15:0] a;
        logic [15:0] b;
        a = rand_sample();
        b = rand_sample();
        push_pair(a, b, int'($urandom_range(0, 3)), {model_gain(b), model_gain(a)});
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            cyc();
            n++;
        end
        check("done_reached", done, 1);
    endtask

    // Codec model, memory slave model and write monitor, all on the negedge.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (!rst_n) begin
                fifo.delete();
                stall_q.delete();
                read_ready      = 1'b0;
                mem_waitrequest = 1'b0;
                gap        = 0;
                stall_left = 0;
                stall_run  = 0;
                write_seen = 1'b0;
                prev_stall = 1'b0;
                prev_rs    = 1'b0;
            end else begin
                // Codec: a strobe retires the head sample; read_ready then
                // drops for a random gap before the next sample is offered.
                if (read_s && read_ready) begin
                    void'(fifo.pop_front());
                    reads++;
                    read_ready = 1'b0;
                    gap = int'($urandom_range(1, 3));
                end else if (gap > 0) begin
                    gap--;
                end else if (!read_ready && fifo.size() > 0) begin
                    read_ready    = 1'b1;
                    readdata_left = fifo[0];
                end
                readdata_right = 16'($urandom);

                if (read_s) begin
                    check("read_s_width", prev_rs, 0);
                    check("read_s_in_write", mem_write, 0);
                end
                prev_rs = read_s;

                // Memory slave: each new write gets its scheduled stall length.
                if (!mem_write) write_seen = 1'b0;
                if (mem_write && !write_seen) begin
                    write_seen = 1'b1;
                    stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                    stall_run  = 0;
                end
                mem_waitrequest = mem_write && (stall_left > 0);
                if (mem_waitrequest) begin
                    stall_left--;
                    stall_run++;
                end

                if (prev_stall) begin
                    check("stall_hold_write", mem_write, 1);
                    check("stall_hold_addr", mem_address, pa);
                    check("stall_hold_data", mem_writedata, pd);
                end
                prev_stall = mem_write && mem_waitrequest;
                pa = mem_address;
                pd = mem_writedata;

                if (mem_write && !mem_waitrequest) begin
                    writes++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                                 mem_address, mem_writedata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", mem_address, e[54:32]);
                        check("write_data", mem_writedata, e[31:0]);
                        check("stall_len", stall_run, e[62:55]);
                    end
                end
            end
        end
    end

    initial begin : main
        logic rs_seen;
        int   r0;
        int   w0;
        int   n;

        rst_n = 1'b0;
        start = 1'b0;
        next_addr = '0;

        // Reset and idle
        repeat (3) cyc();
        check("rst_mem_write", mem_write, 0);
        check("rst_read_s", read_s, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        rs_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            rs_seen = rs_seen | read_s;
        end
        check("idle_read_s", rs_seen, 0);
        check("idle_outputs", {mem_write, mem_address, mem_writedata, busy, done}, 0);
        check("idle_state", state_dbg, 0);
        check("byteenable", mem_byteenable, 4'hF);

        // Capture 1: directed pack, saturation with a 7-cycle stall, random pairs
        next_addr = '0;
        push_pair(16'h000A, 16'hFFFB, 0, 32'hFEC0_0280);
        push_pair(16'h03E8, 16'hFC18, 7, 32'h8000_7FFF);
        push_random_pair();
        push_random_pair();
        pulse_start();
        check("start_busy", busy, 1);
        check("start_state", state_dbg, 1);
        wait_done(3000);
        check("c1_busy", busy, 0);
        check("c1_last_addr", mem_address, 23'(TB_WORDS - 1));
        check("c1_reads", reads, 8);
        check("c1_writes", writes, 4);
        check("c1_queue_empty", exp_q.size(), 0);

        // Samples offered while DONE must not be consumed
        next_addr = '0;
        push_random_pair();
        r0 = reads;
        for (int i = 0; i < 20; i++) cyc();
        check("done_no_reads", reads, r0);
        check("done_held", done, 1);

        // Restart: next capture begins at address 0 with the pending samples
        pulse_start();
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        for (int i = 0; i < 3; i++) push_random_pair();
        wait_done(3000);
        check("c2_writes", writes, 8);
        check("c2_reads", reads, 16);
        check("c2_queue_empty", exp_q.size(), 0);

        // Reset while a write is stalled
        pulse_start();
        next_addr = '0;
        push_pair(rand_sample(), rand_sample(), 100, 32'h0);
        n = 0;
        while (!(mem_write && mem_waitrequest) && n < 500) begin
            cyc();
            n++;
        end
        check("midrst_stalled", mem_write && mem_waitrequest, 1);
        repeat (2) cyc();
        w0 = writes;
        rst_n = 1'b0;
        cyc();
        check("midrst_mem_write", mem_write, 0);
        check("midrst_state", state_dbg, 0);
        check("midrst_addr", mem_address, 0);
        check("midrst_flags", {busy, done, read_s}, 0);
        check("midrst_data", mem_writedata, 0);
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        check("midrst_no_write", writes, w0);
        check("midrst_idle", state_dbg, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_recorder.md
Name: audio_recorder

Overview:
- Capture-side counterpart of the flash playback engine.
- Drains mono samples from the audio codec ADC read path using the read_ready/read_s handshake.
- Applies a saturating gain and packs two consecutive samples per 32-bit word: first sample in [15:0], second in [31:16].
- Writes each word through an Avalon-MM write master into sample memory, in the same word layout the playback engine reads.

Parameters:
- NUM_WORDS, 1048576, number of 32-bit words recorded per capture, addresses 0..NUM_WORDS-1.
- GAIN_SHIFT, 6, arithmetic left-shift applied to each sample, with signed saturation.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  level; starts a capture when sampled high in IDLE or DONE.
- read_ready  in  1  codec has an ADC sample available.
- readdata_left  in  16  codec ADC left sample, signed; the only channel captured.
- readdata_right  in  16  codec ADC right sample; ignored.
- read_s  out  1  codec read strobe.
- mem_write  out  1  Avalon-MM write request.
- mem_address  out  23  word address.
- mem_writedata  out  32  packed sample pair.
- mem_byteenable  out  4  constant 4'b1111.
- mem_waitrequest  in  1  Avalon-MM stall.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n=0 at posedge), from any state including mid-write:
  - state=IDLE.
  - read_s=0, mem_write=0, mem_address=0, mem_writedata=0, done=0, busy=0.
  - Sample registers cleared.
  - No partial word is written after reset.
- All outputs are registered.
- States:
  - IDLE: start=1 -> mem_address<=0, WAIT_RDY1.
  - WAIT_RDY1: read_ready=1 -> capture g(readdata_left) into lo, read_s<=1 for exactly one cycle, ACK1. Otherwise stay, read_s=0.
  - ACK1: read_s<=0; read_ready=0 -> WAIT_RDY2; else stay. Prevents double-consuming one sample.
  - WAIT_RDY2 / ACK2: same as WAIT_RDY1 / ACK1, capturing into hi. ACK2 exits to WRITE with mem_writedata<={hi,lo} and mem_write<=1.
  - WRITE: hold mem_write, mem_address and mem_writedata stable while mem_waitrequest=1. On the first posedge with mem_write=1 and mem_waitrequest=0 the transfer completes: mem_write<=0, then:
    - mem_address==NUM_WORDS-1 -> done<=1, DONE; mem_address holds NUM_WORDS-1.
    - otherwise mem_address<=mem_address+1, WAIT_RDY1.
  - DONE: done=1. start=1 -> done<=0, mem_address<=0, WAIT_RDY1.
- start is ignored outside IDLE and DONE.
- Exactly one write per two consumed samples; no read_s pulses while in WRITE.
- Samples arriving during WRITE stay in the codec FIFO and are consumed afterwards; they are never dropped by this block.
- Gain g(x):
  - y = sign-extended x << GAIN_SHIFT, computed at 16+GAIN_SHIFT bits.
  - y > 32767 -> 16'sh7FFF; y < -32768 -> 16'sh8000; else y[15:0].
  - With GAIN_SHIFT=0, output equals input.
- Handshake latency:
  - read_s rises on the posedge after read_ready is first seen high.
  - mem_write rises on the posedge after the second sample's ACK sees read_ready low.
- readdata_right and the codec write path are untouched.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with start=0 for 20 cycles -> all outputs 0, read_s never pulses.
- Basic pack (GAIN_SHIFT=6, NUM_WORDS=4): codec model supplies readdata_left=16'sd10, then 16'sd-5 -> one write to address 0 with mem_writedata=32'hFEC0_0280; read_s pulses exactly twice, each 1 cycle wide.
- Saturation: samples 16'sd1000 and 16'sd-1000 -> mem_writedata=32'h8000_7FFF.
- Waitrequest stall: hold mem_waitrequest=1 for 7 cycles during WRITE -> mem_write, mem_address and mem_writedata stable for all 7 cycles; exactly one completed write; address advances 0->1 only after waitrequest drops.
- Full run and wrap (NUM_WORDS=4): 8 samples -> writes to addresses 0,1,2,3 with done=1 after the 4th; extra read_ready pulses cause no read_s. start=1 -> done=0 and next write goes to address 0.
- Mid-operation reset: assert rst_n=0 in WRITE with mem_waitrequest=1 -> next cycle mem_write=0, state IDLE, mem_address=0; no write completes.
